// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer: issues ready-handshaked requests, stalls the core, formats load data.
// Optional DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses trap instead of being force-aligned.
module dmem_access_ctrl #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic [31:0]       load_data,
    output logic              access_err,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [3:0]        dmem_be,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_ready,
    input  logic [31:0]       dmem_rdata
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_off;
    logic [2:0]       r_funct3;
    logic             r_is_load;

    logic        w_access;
    logic        w_is_half;
    logic        w_is_word;
    logic        w_illegal_op;
    logic        w_misalign;
    logic        w_illegal;
    logic [1:0]  w_off;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_fmt;

    assign w_access  = mem_read | mem_write;
    assign w_is_half = (funct3[1:0] == 2'b01);
    assign w_is_word = (funct3[1:0] == 2'b10);
    assign stall     = w_access & (r_state != S_DONE);

    // Opcode legality: simultaneous read/write or unsupported width codes
    always_comb begin
        w_illegal_op = 1'b0;
        if (mem_read && mem_write) begin
            w_illegal_op = 1'b1;
        end else if (mem_read) begin
            case (funct3)
                3'b011, 3'b110, 3'b111: w_illegal_op = 1'b1;
                default:                w_illegal_op = 1'b0;
            endcase
        end else if (mem_write) begin
            w_illegal_op = (funct3 > 3'b010);
        end
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    assign w_misalign = (w_is_half & addr[0]) | (w_is_word & (addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_illegal = w_illegal_op | w_misalign;

    // Byte offset after forcing natural alignment of halves and words
    always_comb begin
        w_off = addr[1:0];
        if (w_is_half) begin
            w_off = {addr[1], 1'b0};
        end else if (w_is_word) begin
            w_off = 2'b00;
        end
    end

    // Store lane enables and data replication; loads read the whole word
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = wdata;
        case (funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << w_off;
                w_wdata = {4{wdata[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << w_off;
                w_wdata = {2{wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = wdata;
            end
        endcase
        if (!mem_write) begin
            w_be = 4'b1111;
        end
    end

    // Load formatting from the offset and width captured at issue
    always_comb begin
        case (r_off)
            2'd0:    w_byte = dmem_rdata[7:0];
            2'd1:    w_byte = dmem_rdata[15:8];
            2'd2:    w_byte = dmem_rdata[23:16];
            default: w_byte = dmem_rdata[31:24];
        endcase
        w_half = r_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_fmt = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_fmt = {{16{w_half[15]}}, w_half};
            3'b010:  w_fmt = dmem_rdata;
            3'b100:  w_fmt = {24'd0, w_byte};
            3'b101:  w_fmt = {16'd0, w_half};
            default: w_fmt = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_off      <= 2'd0;
            r_funct3   <= 3'd0;
            r_is_load  <= 1'b0;
            load_data  <= 32'd0;
            access_err <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_be    <= 4'd0;
            dmem_addr  <= '0;
            dmem_wdata <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    access_err <= 1'b0;
                    if (w_access) begin
                        if (w_illegal) begin
                            r_state    <= S_DONE;
                            access_err <= 1'b1;
                            load_data  <= 32'd0;
                        end else begin
                            r_state    <= S_WAIT;
                            r_cnt      <= '0;
                            r_off      <= w_off;
                            r_funct3   <= funct3;
                            r_is_load  <= mem_read;
                            dmem_req   <= 1'b1;
                            dmem_we    <= mem_write;
                            dmem_be    <= w_be;
                            dmem_addr  <= {addr[ADDR_W-1:2], 2'b00};
                            dmem_wdata <= w_wdata;
                        end
                    end
                end
                S_WAIT: begin
                    if (dmem_ready) begin
                        r_state  <= S_DONE;
                        dmem_req <= 1'b0;
                        if (r_is_load) begin
                            load_data <= w_fmt;
                        end
                    end else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        r_state    <= S_DONE;
                        dmem_req   <= 1'b0;
                        access_err <= 1'b1;
                        load_data  <= 32'd0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    access_err <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: driver pushes expectations from a spec-level model,
// a memory responder injects latency, and a monitor checks retirements and requests.
module tb_dmem_access_ctrl;

    localparam int unsigned TO = 6;

    typedef struct {
        bit          err;
        bit          chk_ld;
        logic [31:0] ld;
        int          ncyc;
    } exp_t;

    typedef struct {
        bit          we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wd;
        bit          chk_wd;
    } req_t;

    typedef struct {
        int          lat;
        logic [31:0] rd;
    } mem_t;

    logic        clk;
    logic        rst_n;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] load_data;
    logic        access_err;
    logic        dmem_req;
    logic        dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    exp_t exp_q[$];
    req_t req_q[$];
    mem_t mem_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 0;

    dmem_access_ctrl #(
        .ADDR_W      (32),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .stall      (stall),
        .load_data  (load_data),
        .access_err (access_err),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_be    (dmem_be),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ready (dmem_ready),
        .dmem_rdata (dmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, want, $time);
        end
    endtask

    task automatic flag_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Reference model: expected request, completion and stall length from the access rules
    task automatic model_push(input bit mr, input bit mw, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rd, input int lat);
        exp_t e;
        req_t r;
        mem_t m;
        bit illegal;
        int size;
        longint unsigned av, rdv, ea, off, mask, v;
        illegal = (mr && mw) || (mr && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) || (mw && f3 > 3'd2);
        size = 1 << f3[1:0];
        av   = a;
        rdv  = rd;
`ifdef DMEM_MISALIGN_TRAP_EN
        if (!illegal && (av % size) != 0) illegal = 1;
`endif
        e.err = 0; e.chk_ld = 0; e.ld = 0; e.ncyc = 0;
        if (illegal) begin
            e.err = 1; e.chk_ld = 1; e.ld = 0; e.ncyc = 1;
        end else begin
            ea  = av - (av % size);
            off = ea % 4;
            r.we     = mw;
            r.addr   = 32'((av / 4) * 4);
            r.chk_wd = mw;
            if (mw) begin
                r.be = 4'(((64'd1 << size) - 1) << off);
                case (size)
                    1:       r.wd = (wd % 256) * 32'h01010101;
                    2:       r.wd = (wd % 65536) * 32'h00010001;
                    default: r.wd = wd;
                endcase
            end else begin
                r.be = 4'hF;
                r.wd = 32'd0;
            end
            req_q.push_back(r);
            m.lat = lat;
            m.rd  = rd;
            mem_q.push_back(m);
            if (lat >= TO) begin
                e.err = 1; e.chk_ld = 1; e.ld = 0; e.ncyc = 1 + TO;
            end else begin
                e.ncyc   = lat + 2;
                e.chk_ld = mr;
                mask = (64'd1 << (8 * size)) - 1;
                v    = (rdv >> (8 * off)) & mask;
                if (f3 < 3'd4 && size < 4 && v >= (mask + 1) / 2) v = v + (64'hFFFF_FFFF - mask);
                e.ld = 32'(v);
            end
        end
        exp_q.push_back(e);
    endtask

    // Issue one instruction and hold it until the core may retire it
    task automatic run_txn(input bit mr, input bit mw, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rd, input int lat);
        bit done;
        @(posedge clk); #1;
        mem_read  = mr;
        mem_write = mw;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        model_push(mr, mw, f3, a, wd, rd, lat);
        done = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!stall) begin
                done = 1;
                break;
            end
            if (dmem_req) begin
                funct3 = 3'($urandom);
                addr   = $urandom;
                wdata  = $urandom;
            end
        end
        if (!done) flag_fail("retire_timeout");
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            mem_read  = 0;
            mem_write = 0;
            funct3    = 3'($urandom);
            addr      = $urandom;
        end
    endtask

    // Memory model: ready after the programmed number of WAIT cycles, noise on ready otherwise
    initial begin : responder
        bit   active;
        int   idx;
        mem_t m;
        active = 0;
        idx = 0;
        m.lat = 0; m.rd = 0;
        dmem_ready = 0;
        dmem_rdata = 0;
        forever begin
            @(posedge clk); #1;
            if (dmem_req) begin
                if (!active) begin
                    active = 1;
                    idx = 0;
                    if (mem_q.size() > 0) m = mem_q.pop_front();
                    else begin m.lat = 1000; m.rd = 0; end
                end
                dmem_ready = (idx == m.lat);
                dmem_rdata = (idx == m.lat) ? m.rd : $urandom;
                idx++;
            end else begin
                active = 0;
                dmem_ready = 1'($urandom_range(0, 1));
                dmem_rdata = $urandom;
            end
        end
    end

    // Monitor: request contents/stability, stall length and retirement results
    initial begin : monitor
        int   stall_cnt;
        bit   prev_req;
        req_t hold;
        req_t r;
        exp_t e;
        stall_cnt = 0;
        prev_req  = 0;
        hold.we = 0; hold.be = 0; hold.addr = 0; hold.wd = 0; hold.chk_wd = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                stall_cnt = 0;
                prev_req  = 0;
            end else begin
                if (!(mem_read || mem_write)) begin
                    check("stall_no_access", 32'(stall), 32'd0);
                    check("err_no_access", 32'(access_err), 32'd0);
                end else if (stall) begin
                    stall_cnt++;
                    check("err_while_stalled", 32'(access_err), 32'd0);
                end else begin
                    if (exp_q.size() == 0) begin
                        flag_fail("retire_unexpected");
                    end else begin
                        e = exp_q.pop_front();
                        check("stall_cycles", 32'(stall_cnt), 32'(e.ncyc));
                        check("access_err", 32'(access_err), 32'(e.err));
                        if (e.chk_ld) check("load_data", load_data, e.ld);
                        check("req_low_at_retire", 32'(dmem_req), 32'd0);
                    end
                    stall_cnt = 0;
                end
                if (dmem_req && !prev_req) begin
                    if (req_q.size() == 0) begin
                        flag_fail("req_unexpected");
                    end else begin
                        r = req_q.pop_front();
                        check("dmem_we", 32'(dmem_we), 32'(r.we));
                        check("dmem_be", 32'(dmem_be), 32'(r.be));
                        check("dmem_addr", dmem_addr, r.addr);
                        if (r.chk_wd) check("dmem_wdata", dmem_wdata, r.wd);
                    end
                    hold.we = dmem_we; hold.be = dmem_be; hold.addr = dmem_addr; hold.wd = dmem_wdata;
                end else if (dmem_req) begin
                    check("req_stable_be", 32'(dmem_be), 32'(hold.be));
                    check("req_stable_addr", dmem_addr, hold.addr);
                    check("req_stable_wdata", dmem_wdata, hold.wd);
                    check("req_stable_we", 32'(dmem_we), 32'(hold.we));
                end
                prev_req = dmem_req;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        bit          mr, mw, got_req;
        logic [2:0]  f3;
        int          k, lat;
        logic [2:0]  ld_f3 [5];
        logic [2:0]  st_f3 [3];
        ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        st_f3 = '{3'b000, 3'b001, 3'b010};
        rst_n = 0; mem_read = 0; mem_write = 0; funct3 = 0; addr = 0; wdata = 0;
        #1;
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_we", 32'(dmem_we), 32'd0);
        check("rst_err", 32'(access_err), 32'd0);
        check("rst_be", 32'(dmem_be), 32'd0);
        check("rst_addr", dmem_addr, 32'd0);
        check("rst_wdata", dmem_wdata, 32'd0);
        check("rst_load_data", load_data, 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        repeat (2) @(negedge clk);
        rst_n  = 1;
        mon_en = 1;

        run_txn(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 0);
        run_txn(0, 1, 3'b001, 32'h22, 32'h0000BEEF, 32'h0, 0);
        run_txn(1, 0, 3'b101, 32'h42, 32'h0, 32'h9ABC0000, 4);
        run_txn(1, 0, 3'b010, 32'h80, 32'h0, 32'h0, 99);
        idle_gap(2);
        run_txn(1, 1, 3'b010, 32'h10, 32'h0, 32'h0, 0);
        run_txn(1, 0, 3'b011, 32'h10, 32'h0, 32'h0, 0);
        run_txn(0, 1, 3'b100, 32'h10, 32'h12345678, 32'h0, 0);
        run_txn(1, 0, 3'b010, 32'h06, 32'h0, 32'h11223344, 1);
        run_txn(0, 1, 3'b000, 32'h201, 32'hCAFE00A5, 32'h0, 2);
        run_txn(1, 0, 3'b001, 32'h2FE, 32'h0, 32'h8001_7F00, TO - 1);

        for (int n = 0; n < 200; n++) begin
            k  = $urandom_range(0, 19);
            mr = (k < 9) || (k >= 18);
            mw = (k >= 9);
            if ($urandom_range(0, 3) == 0) f3 = 3'($urandom);
            else if (mr) f3 = ld_f3[$urandom_range(0, 4)];
            else f3 = st_f3[$urandom_range(0, 2)];
            lat = ($urandom_range(0, 7) == 0) ? $urandom_range(4, TO + 2) : $urandom_range(0, 3);
            run_txn(mr, mw, f3, $urandom, $urandom, $urandom, lat);
            if ($urandom_range(0, 2) == 0) idle_gap($urandom_range(1, 2));
        end
        idle_gap(2);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("req_q_drained", 32'(req_q.size()), 32'd0);

        // Reset in the middle of an outstanding request
        mon_en = 0;
        @(posedge clk); #1;
        mem_read = 1; mem_write = 0; funct3 = 3'b010; addr = 32'h10;
        mem_q.push_back('{lat: 100, rd: 32'h0});
        got_req = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dmem_req) begin
                got_req = 1;
                break;
            end
        end
        if (!got_req) flag_fail("reset_test_no_req");
        @(negedge clk); #2;
        rst_n = 0;
        #1;
        check("async_rst_req", 32'(dmem_req), 32'd0);
        check("async_rst_stall_idle", 32'(stall), 32'd1);
        check("async_rst_err", 32'(access_err), 32'd0);
        mem_read = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_req", 32'(dmem_req), 32'd0);
            check("post_rst_err", 32'(access_err), 32'd0);
        end
        exp_q.delete();
        req_q.delete();
        mem_q.delete();
        mon_en = 1;
        run_txn(1, 0, 3'b100, 32'h7, 32'h0, 32'hA1B2C3D4, 0);
        idle_gap(2);
        check("final_exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
